osc_freq_monitor: RTL and testbench

//  Frequency monitor clocked by the 160 MHz on-chip RC oscillator global clock (RCOSC_160MHZ_GL).
//  - Counts rising edges of an asynchronous measured clock MEAS_IN over a fixed gate of GATE_CYCLES CLK cycles.
//  - Reports the count and range-checks it against limits, so firmware/fabric can qualify the RC oscillator against a

---
 rtl/osc_mon_pkg.sv | 17 +
 rtl/osc_mon_sync_edge.sv | 28 ++
 rtl/osc_freq_monitor.sv | 116 +++++++++++
 tb/tb_osc_freq_monitor.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/osc_mon_pkg.sv
// Shared constants for the oscillator frequency monitor: FSM state encoding
// and default gate/limit values for a 10 MHz reference measured from a 160 MHz clock.
package osc_mon_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ARM    = 2'd1;
    localparam logic [1:0] ST_GATE   = 2'd2;
    localparam logic [1:0] ST_REPORT = 2'd3;

    // 1 ms gate at 160 MHz; 10 MHz reference expects 10000 edges, +/-1 %
    localparam int unsigned DEF_GATE_CYCLES = 160000;
    localparam int unsigned DEF_CNT_W       = 20;
    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam int unsigned DEF_LO_LIMIT    = 9900;
    localparam int unsigned DEF_HI_LIMIT    = 10100;

endpackage

// File: rtl/osc_mon_sync_edge.sv
// Synchronizes the asynchronous measured clock into the CLK domain and
// produces a one-cycle pulse for each rising edge.
module osc_mon_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_resetn,
    input  logic i_d,
    output logic o_edge
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Synchronizer chain plus one delayed copy for edge detection
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_edge = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/osc_freq_monitor.sv
// Counts rising edges of an asynchronous clock over a fixed gate of CLK cycles,
// reports the count each gate and range-checks it with a sticky fault flag.
module osc_freq_monitor
    import osc_mon_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = DEF_GATE_CYCLES,
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned LO_LIMIT    = DEF_LO_LIMIT,
    parameter int unsigned HI_LIMIT    = DEF_HI_LIMIT
) (
    input  logic             i_clk,
    input  logic             i_resetn,
    input  logic             i_en,
    input  logic             i_meas_in,
    input  logic             i_fault_clr,
    output logic [CNT_W-1:0] o_count,
    output logic             o_count_valid,
    output logic             o_in_range,
    output logic             o_fault
);

    localparam int unsigned      GW        = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LO        = CNT_W'(LO_LIMIT);
    localparam logic [CNT_W-1:0] HI        = CNT_W'(HI_LIMIT);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [GW-1:0]    r_gate_cnt;
    logic [CNT_W-1:0] r_edge_cnt;
    logic [CNT_W-1:0] r_count;
    logic             r_count_valid;
    logic             r_in_range;
    logic             r_fault;
    logic             w_edge;
    logic             w_gate_last;
    logic             w_sat;
    logic             w_in_range;

    osc_mon_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .i_clk    (i_clk),
        .i_resetn (i_resetn),
        .i_d      (i_meas_in),
        .o_edge   (w_edge)
    );

    assign w_gate_last = (r_gate_cnt == GATE_LAST);
    assign w_sat       = &r_edge_cnt;
    assign w_in_range  = (r_edge_cnt >= LO) && (r_edge_cnt <= HI);

    // Next-state decode; EN low aborts ARM/GATE but lets REPORT finish
    always_comb begin
        w_state_nxt = ST_IDLE;
        case (r_state)
            ST_IDLE:   w_state_nxt = i_en ? ST_ARM : ST_IDLE;
            ST_ARM:    w_state_nxt = i_en ? ST_GATE : ST_IDLE;
            ST_GATE: begin
                if (!i_en)            w_state_nxt = ST_IDLE;
                else if (w_gate_last) w_state_nxt = ST_REPORT;
                else                  w_state_nxt = ST_GATE;
            end
            ST_REPORT: w_state_nxt = i_en ? ST_ARM : ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // State register, gate counter and saturating edge counter
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state    <= ST_IDLE;
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_ARM) begin
                r_gate_cnt <= '0;
                r_edge_cnt <= '0;
            end else if (r_state == ST_GATE) begin
                r_gate_cnt <= r_gate_cnt + GW'(1);
                if (w_edge && !w_sat) begin
                    r_edge_cnt <= r_edge_cnt + CNT_W'(1);
                end
            end
        end
    end

    // Result registers; a failing report wins over a simultaneous fault clear
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_count       <= '0;
            r_count_valid <= 1'b0;
            r_in_range    <= 1'b0;
            r_fault       <= 1'b0;
        end else begin
            r_count_valid <= (r_state == ST_REPORT);
            if (r_state == ST_REPORT) begin
                r_count    <= r_edge_cnt;
                r_in_range <= w_in_range;
            end
            if ((r_state == ST_REPORT) && !w_in_range) begin
                r_fault <= 1'b1;
            end else if (i_fault_clr) begin
                r_fault <= 1'b0;
            end
        end
    end

    assign o_count       = r_count;
    assign o_count_valid = r_count_valid;
    assign o_in_range    = r_in_range;
    assign o_fault       = r_fault;

endmodule

// File: tb/tb_osc_freq_monitor.sv
// Directed + randomized bench for osc_freq_monitor with a short gate.
// Expected counts come from the measured period: a window of G cycles holds
// either floor(G/p) or ceil(G/p) rising edges of a period-p clock.
module tb_osc_freq_monitor;

    localparam int unsigned G  = 1600;
    localparam int unsigned LO = 99;
    localparam int unsigned HI = 101;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        en    = 1'b0;
    logic        meas  = 1'b0;
    logic        fclr  = 1'b0;
    logic        en2   = 1'b0;
    logic        meas2 = 1'b0;
    logic [19:0] count;
    logic        valid, inr, fault;
    logic [5:0]  count2;
    logic        valid2, inr2, fault2;

    int n_chk     = 0;
    int n_fail    = 0;
    int meas_p    = 16;  // measured clock period in CLK cycles
    int meas_mode = 0;   // 0 toggling, 1 stuck low, 2 stuck high

    osc_freq_monitor #(
        .GATE_CYCLES (G),
        .CNT_W       (20),
        .SYNC_STAGES (2),
        .LO_LIMIT    (LO),
        .HI_LIMIT    (HI)
    ) dut (
        .i_clk         (clk),
        .i_resetn      (rst_n),
        .i_en          (en),
        .i_meas_in     (meas),
        .i_fault_clr   (fclr),
        .o_count       (count),
        .o_count_valid (valid),
        .o_in_range    (inr),
        .o_fault       (fault)
    );

    // Narrow counter instance driven at CLK/4 to exercise saturation
    osc_freq_monitor #(
        .GATE_CYCLES (G),
        .CNT_W       (6),
        .SYNC_STAGES (2),
        .LO_LIMIT    (LO),
        .HI_LIMIT    (HI)
    ) dut_sat (
        .i_clk         (clk),
        .i_resetn      (rst_n),
        .i_en          (en2),
        .i_meas_in     (meas2),
        .i_fault_clr   (1'b0),
        .o_count       (count2),
        .o_count_valid (valid2),
        .o_in_range    (inr2),
        .o_fault       (fault2)
    );

    always #5 clk = ~clk;

    // Measured clock; transitions stay 2 time units clear of CLK rising edges
    initial begin
        #3;
        forever begin
            if (meas_mode == 0) begin
                #(meas_p * 5);
                meas = ~meas;
            end else begin
                meas = (meas_mode == 2);
                #5;
            end
        end
    end

    initial begin
        #3;
        forever begin
            #20;
            meas2 = ~meas2;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_count(input string tag, input int p);
        int c;
        bit ok;
        c  = int'(count);
        ok = (c * p > int'(G) - p) && (c * p < int'(G) + p);
        n_chk++;
        assert (ok) else begin
            n_fail++;
            $error("FAIL %s: observed count %0d expected %0d/%0d rounded either way",
                   tag, c, G, p);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag, input int budget, output int waited);
        bit got;
        got    = 1'b0;
        waited = 0;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clk);
            #1;
            if (valid) begin
                got    = 1'b1;
                waited = i;
                break;
            end
        end
        if (!got) check({tag, " timeout"}, int'(got), 1);
    endtask

    initial begin
        int w;
        int p;
        int seen;

        // Reset state
        #2;
        check("reset count", int'(count), 0);
        check("reset valid", int'(valid), 0);
        check("reset in_range", int'(inr), 0);
        check("reset fault", int'(fault), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        en    = 1'b1;
        en2   = 1'b1;

        // 1: 10 MHz reference, in range
        wait_valid("t1 first", 1700, w);
        check("t1 first latency", w, 1603);
        check_count("t1 count a", 16);
        check("t1 in_range a", int'(inr), 1);
        check("t1 fault a", int'(fault), 0);
        wait_valid("t1 second", 1700, w);
        check("t1 period", w, 1602);
        check_count("t1 count b", 16);
        check("t1 in_range b", int'(inr), 1);

        // 2: 8 MHz is out of range, then recover with FAULT_CLR
        meas_p = 20;
        wait_valid("t2 discard", 1700, w);
        wait_valid("t2 slow", 1700, w);
        check("t2 period", w, 1602);
        check_count("t2 count", 20);
        check("t2 in_range", int'(inr), 0);
        check("t2 fault", int'(fault), 1);
        meas_p = 16;
        wait_valid("t2 discard2", 1700, w);
        step(10);
        fclr = 1'b1;
        step(1);
        fclr = 1'b0;
        check("t2 fault cleared", int'(fault), 0);
        wait_valid("t2 recover", 1700, w);
        check_count("t2 recover count", 16);
        check("t2 recover in_range", int'(inr), 1);
        check("t2 recover fault", int'(fault), 0);

        // Randomized periods
        repeat (4) begin
            p      = int'($urandom_range(5, 40));
            meas_p = p;
            wait_valid("rand discard", 1700, w);
            wait_valid("rand", 1700, w);
            check_count("rand count", p);
            check("rand in_range", int'(inr), (p == 16) ? 1 : 0);
            if (p != 16) check("rand fault", int'(fault), 1);
        end

        // 3: stuck measured clock, and clear colliding with a failing report
        meas_mode = 1;
        wait_valid("t3 discard0", 1700, w);
        wait_valid("t3 stuck0", 1700, w);
        check("t3 stuck0 count", int'(count), 0);
        check("t3 stuck0 in_range", int'(inr), 0);
        check("t3 stuck0 fault", int'(fault), 1);
        meas_mode = 2;
        wait_valid("t3 discard1", 1700, w);
        wait_valid("t3 stuck1", 1700, w);
        check("t3 stuck1 count", int'(count), 0);
        check("t3 stuck1 fault", int'(fault), 1);
        step(1601);
        fclr = 1'b1;
        step(1);
        fclr = 1'b0;
        check("t3 collide valid", int'(valid), 1);
        check("t3 collide fault", int'(fault), 1);

        // 4: EN dropped mid-gate
        meas_mode = 0;
        meas_p    = 16;
        wait_valid("t4 discard", 1700, w);
        fclr = 1'b1;
        step(1);
        fclr = 1'b0;
        wait_valid("t4 ref", 1700, w);
        check("t4 ref count", int'(count), 100);
        step(801);
        en   = 1'b0;
        seen = 0;
        for (int i = 0; i < 2000; i++) begin
            step(1);
            if (valid) seen++;
        end
        check("t4 no valid", seen, 0);
        check("t4 count holds", int'(count), 100);
        check("t4 in_range holds", int'(inr), 1);
        en = 1'b1;
        wait_valid("t4 restart", 1700, w);
        check("t4 restart latency", w, 1603);
        check_count("t4 restart count", 16);

        // 5: reset pulsed mid-gate
        meas_p = 20;
        wait_valid("t5 discard", 1700, w);
        step(500);
        rst_n = 1'b0;
        #1;
        check("t5 reset count", int'(count), 0);
        check("t5 reset valid", int'(valid), 0);
        check("t5 reset in_range", int'(inr), 0);
        check("t5 reset fault", int'(fault), 0);
        step(3);
        rst_n = 1'b1;
        wait_valid("t5 restart", 1700, w);
        check("t5 restart latency", w, 1603);
        check_count("t5 restart count", 20);
        check("t5 restart fault", int'(fault), 1);

        // 6: narrow counter saturates instead of wrapping (400 edges per gate)
        check("t6 sat count", int'(count2), 63);
        check("t6 sat in_range", int'(inr2), 0);
        check("t6 sat fault", int'(fault2), 1);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
